// File: rtl/bit_sync_filt.sv
// ---------------------------------------------------------------------------
// bit_sync_filt
//
// Multi-channel single-bit synchronizer with a per-channel stability filter
// and registered edge strobes. Each channel runs through its own flop chain,
// then must hold a new level for FILTER_CYCLES consecutive synchronized
// cycles before SYNC takes it. RISE/FALL pulse for one cycle together with
// the SYNC change.
//
// Parameters:
//   BUS_WIDTH     - number of independent channels (>=1)
//   NUM_STAGES    - synchronizer flops per channel (>=2)
//   FILTER_CYCLES - cycles a new level must hold before it is accepted (>=1)
//   RESET_VALUE   - value loaded into the sync chains and SYNC on reset
//
// Ports:
//   CLK      in   clock for all logic
//   RST      in   synchronous active-high reset
//   ASYNC    in   [BUS_WIDTH] asynchronous inputs
//   SYNC     out  [BUS_WIDTH] filtered synchronized levels (registered)
//   RISE     out  [BUS_WIDTH] one-cycle strobe on SYNC 0->1
//   FALL     out  [BUS_WIDTH] one-cycle strobe on SYNC 1->0
//   ANY_EDGE out  OR of all RISE and FALL bits
// ---------------------------------------------------------------------------
module bit_sync_filt #(
    parameter int                   BUS_WIDTH     = 1,
    parameter int                   NUM_STAGES    = 2,
    parameter int                   FILTER_CYCLES = 1,
    parameter logic [BUS_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] ASYNC,
    output logic [BUS_WIDTH-1:0] SYNC,
    output logic [BUS_WIDTH-1:0] RISE,
    output logic [BUS_WIDTH-1:0] FALL,
    output logic                 ANY_EDGE
);

    // Counter only needs to reach FILTER_CYCLES-1; keep at least one bit so
    // the unfiltered case still has a legal vector.
    localparam int CNT_W = ($clog2(FILTER_CYCLES + 1) < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_ch
        logic [NUM_STAGES-1:0] stages;
        logic [CNT_W-1:0]      count;
        logic                  sync_r;
        logic                  rise_r;
        logic                  fall_r;
        logic                  s_bit;

        // Only stages[0] samples ASYNC; it is read solely by stages[1].
        always_ff @(posedge CLK) begin
            if (RST) begin
                stages <= {NUM_STAGES{RESET_VALUE[i]}};
            end else begin
                stages <= {stages[NUM_STAGES-2:0], ASYNC[i]};
            end
        end

        assign s_bit = stages[NUM_STAGES-1];

        // A differing level is accepted only after it has differed for
        // FILTER_CYCLES edges in a row; any return to SYNC restarts the count.
        // The strobe registers are cleared every cycle they are not set, so
        // each pulse lasts exactly one cycle.
        always_ff @(posedge CLK) begin
            if (RST) begin
                sync_r <= RESET_VALUE[i];
                count  <= '0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                if (s_bit == sync_r) begin
                    count <= '0;
                end else if (count == CNT_LAST) begin
                    sync_r <= s_bit;
                    count  <= '0;
                    rise_r <= s_bit;
                    fall_r <= ~s_bit;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end

        assign SYNC[i] = sync_r;
        assign RISE[i] = rise_r;
        assign FALL[i] = fall_r;
    end

    assign ANY_EDGE = (|RISE) | (|FALL);

endmodule

// File: tb/tb_bit_sync_filt.sv
// ---------------------------------------------------------------------------
// tb_bit_sync_filt
//
// Three differently parameterised instances share clock and reset:
//   A: 4 channels, 3 stages, filter 4, reset 0000
//   B: 1 channel,  2 stages, filter 1, reset 1
//   C: 2 channels, 2 stages, filter 8, reset 10
// A behavioural model keeps the raw input history per channel and accepts a
// new level once the most recent FILTER_CYCLES synchronized samples (taken
// since the last acceptance or reset) all differ from the current level.
// ---------------------------------------------------------------------------
module tb_bit_sync_filt;

    localparam int   NS  [3] = '{3, 2, 2};
    localparam int   FC  [3] = '{4, 1, 8};
    localparam int   BW  [3] = '{4, 1, 2};
    localparam logic [3:0] RVV [3] = '{4'b0000, 4'b0001, 4'b0010};

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] asyncA = '0;
    logic [0:0] asyncB = '0;
    logic [1:0] asyncC = '0;
    logic [3:0] syncA, riseA, fallA;
    logic [0:0] syncB, riseB, fallB;
    logic [1:0] syncC, riseC, fallC;
    logic       anyA, anyB, anyC;

    int total = 0;
    int bad   = 0;

    int riseCnt [3];
    int fallCnt [3];
    int bothCnt [3];

    // Model state
    bit mChain [3][4][8];
    bit mHist  [3][4][16];
    int mLen   [3][4];
    bit mSync  [3][4];
    bit mRise  [3][4];
    bit mFall  [3][4];

    always #5 CLK = ~CLK;

    bit_sync_filt #(.BUS_WIDTH(4), .NUM_STAGES(3), .FILTER_CYCLES(4), .RESET_VALUE(4'b0000)) dutA (
        .CLK(CLK), .RST(RST), .ASYNC(asyncA), .SYNC(syncA), .RISE(riseA), .FALL(fallA), .ANY_EDGE(anyA));

    bit_sync_filt #(.BUS_WIDTH(1), .NUM_STAGES(2), .FILTER_CYCLES(1), .RESET_VALUE(1'b1)) dutB (
        .CLK(CLK), .RST(RST), .ASYNC(asyncB), .SYNC(syncB), .RISE(riseB), .FALL(fallB), .ANY_EDGE(anyB));

    bit_sync_filt #(.BUS_WIDTH(2), .NUM_STAGES(2), .FILTER_CYCLES(8), .RESET_VALUE(2'b10)) dutC (
        .CLK(CLK), .RST(RST), .ASYNC(asyncC), .SYNC(syncC), .RISE(riseC), .FALL(fallC), .ANY_EDGE(anyC));

    // Single point of comparison and failure reporting
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // One clock edge of the reference behaviour for instance d
    task automatic modelStep(input int d, input logic [3:0] a, input logic r);
        bit s;
        bit accept;
        for (int c = 0; c < BW[d]; c++) begin
            mRise[d][c] = 1'b0;
            mFall[d][c] = 1'b0;
            if (r) begin
                for (int k = 0; k < 8; k++) mChain[d][c][k] = RVV[d][c];
                mSync[d][c] = RVV[d][c];
                mLen[d][c]  = 0;
            end else begin
                s = mChain[d][c][NS[d]-1];
                for (int k = 15; k > 0; k--) mHist[d][c][k] = mHist[d][c][k-1];
                mHist[d][c][0] = s;
                if (mLen[d][c] < 16) mLen[d][c]++;
                accept = (mLen[d][c] >= FC[d]);
                for (int k = 0; k < FC[d]; k++)
                    if (mHist[d][c][k] == mSync[d][c]) accept = 1'b0;
                if (accept) begin
                    mSync[d][c] = s;
                    mRise[d][c] = s;
                    mFall[d][c] = ~s;
                    mLen[d][c]  = 0;
                end
                for (int k = 7; k > 0; k--) mChain[d][c][k] = mChain[d][c][k-1];
                mChain[d][c][0] = a[c];
            end
        end
    endtask

    function automatic logic [3:0] packModel(input int d, input int which);
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < BW[d]; c++)
            v[c] = (which == 0) ? mSync[d][c] : (which == 1) ? mRise[d][c] : mFall[d][c];
        return v;
    endfunction

    function automatic logic [3:0] obsVec(input int d, input int which);
        logic [3:0] v;
        v = '0;
        case (d)
            0: v = (which == 0) ? syncA : (which == 1) ? riseA : fallA;
            1: v = {3'b000, (which == 0) ? syncB : (which == 1) ? riseB : fallB};
            default: v = {2'b00, (which == 0) ? syncC : (which == 1) ? riseC : fallC};
        endcase
        return v;
    endfunction

    function automatic logic obsAny(input int d);
        return (d == 0) ? anyA : (d == 1) ? anyB : anyC;
    endfunction

    // Advance one edge, update model, then compare away from the edge
    task automatic applyStimulus();
        logic [3:0] er, ef;
        @(posedge CLK);
        modelStep(0, asyncA, RST);
        modelStep(1, {3'b000, asyncB}, RST);
        modelStep(2, {2'b00, asyncC}, RST);
        #1;
        for (int d = 0; d < 3; d++) begin
            er = packModel(d, 1);
            ef = packModel(d, 2);
            checkOutput($sformatf("sync%0d", d), 32'(obsVec(d, 0)), 32'(packModel(d, 0)));
            checkOutput($sformatf("rise%0d", d), 32'(obsVec(d, 1)), 32'(er));
            checkOutput($sformatf("fall%0d", d), 32'(obsVec(d, 2)), 32'(ef));
            checkOutput($sformatf("any%0d", d), 32'(obsAny(d)), 32'((|er) | (|ef)));
            riseCnt[d] += $countones(obsVec(d, 1));
            fallCnt[d] += $countones(obsVec(d, 2));
            bothCnt[d] += $countones(obsVec(d, 1) & obsVec(d, 2));
        end
    endtask

    task automatic clearCounts();
        for (int d = 0; d < 3; d++) begin
            riseCnt[d] = 0;
            fallCnt[d] = 0;
            bothCnt[d] = 0;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) applyStimulus();
    endtask

    initial begin
        int n;
        int holdA, holdB, holdC;

        // Reset held three cycles with inputs low
        RST = 1'b1;
        settle(3);
        checkOutput("rstSyncB", 32'(syncB), 32'd1);
        checkOutput("rstSyncC", 32'(syncC), 32'h2);

        // Release: B must drop after NS+FC edges with a single FALL
        clearCounts();
        RST = 1'b0;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (syncB !== 1'b0 && n < 10);
        checkOutput("rstRelLatB", n, NS[1] + FC[1]);
        settle(12);
        checkOutput("rstFallB", fallCnt[1], 1);
        checkOutput("rstRiseB", riseCnt[1], 0);

        // Latency on A: 0000 -> 0101
        clearCounts();
        asyncA = 4'b0101;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (syncA !== 4'b0101 && n < 20);
        checkOutput("latA", n, NS[0] + FC[0]);
        checkOutput("latRiseA", 32'(riseA), 32'h5);
        checkOutput("latAnyA", 32'(anyA), 32'd1);
        applyStimulus();
        checkOutput("latRiseOnceA", 32'(riseA), 32'h0);
        asyncA = 4'b0000;
        settle(12);

        // Glitch of 3 cycles is rejected, 4 cycles accepted
        clearCounts();
        asyncA[0] = 1'b1;
        settle(3);
        asyncA[0] = 1'b0;
        settle(12);
        checkOutput("glitchRej", riseCnt[0], 0);
        asyncA[0] = 1'b1;
        settle(4);
        asyncA[0] = 1'b0;
        settle(12);
        checkOutput("glitchAcc", riseCnt[0], 1);
        settle(4);

        // Count restart: high 2, low 1, high held
        clearCounts();
        asyncA[0] = 1'b1;
        settle(2);
        asyncA[0] = 1'b0;
        settle(1);
        asyncA[0] = 1'b1;
        settle(14);
        checkOutput("restartRise", riseCnt[0], 1);
        asyncA[0] = 1'b0;
        settle(12);

        // Toggle every cycle on B (no filtering)
        clearCounts();
        for (int k = 0; k < 8; k++) begin
            asyncB = ~asyncB;
            applyStimulus();
        end
        asyncB = 1'b0;
        settle(6);
        checkOutput("toggleRise", riseCnt[1], 4);
        checkOutput("toggleFall", fallCnt[1], 4);
        checkOutput("toggleBoth", bothCnt[1], 0);

        // Reset while C's channel 0 has counted 5 of 8
        clearCounts();
        asyncC = 2'b11;
        settle(NS[2] + 5);
        checkOutput("midSyncC", 32'(syncC), 32'h0);
        RST = 1'b1;
        applyStimulus();
        checkOutput("midRstSyncC", 32'(syncC), 32'h2);
        RST = 1'b0;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (syncC[0] !== 1'b1 && n < 30);
        checkOutput("midRequal", n, NS[2] + FC[2]);
        checkOutput("midRiseC", riseCnt[2], 1);

        // Randomized run with held levels and occasional resets
        holdA = 0;
        holdB = 0;
        holdC = 0;
        for (int k = 0; k < 600; k++) begin
            if (holdA == 0) begin asyncA = 4'($urandom); holdA = $urandom_range(1, 9); end
            if (holdB == 0) begin asyncB = 1'($urandom); holdB = $urandom_range(1, 3); end
            if (holdC == 0) begin asyncC = 2'($urandom); holdC = $urandom_range(1, 14); end
            holdA--;
            holdB--;
            holdC--;
            RST = ($urandom_range(0, 80) == 0);
            applyStimulus();
        end
        RST = 1'b0;
        settle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
